// File: rtl/cw_byte_packer.sv
// Constant-weight codeword byte packer: queues CW_W-bit codewords in a small
// FIFO and serialises them MSB-first onto a valid/ready byte stream with framing.
module cw_byte_packer #(
    parameter int CW_W       = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [CW_W-1:0] cw_in,
    input  logic            cw_rdy,
    input  logic            cw_done,
    output logic [7:0]      byte_out,
    output logic            byte_valid,
    input  logic            byte_ready,
    output logic            byte_last,
    output logic            frame_done,
    output logic            err
);

    localparam int ACC_W  = CW_W + 8;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BCNT_W = $clog2(ACC_W);

    localparam logic [PTR_W:0]    FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] BYTE_BITS     = BCNT_W'(8);
    localparam logic [BCNT_W-1:0] CW_BITS       = BCNT_W'(CW_W);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Codeword FIFO storage and pointers
    logic [CW_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [PTR_W:0]    count_q;
    logic [PTR_W:0]    count_d;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW_W-1:0]   fifo_rd_s;

    // Packing datapath and control
    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [BCNT_W-1:0] bcnt_q;
    logic [BCNT_W-1:0] bcnt_d;
    logic [7:0]        byte_q;
    logic [7:0]        byte_d;
    logic              valid_q;
    logic              valid_d;
    logic              last_q;
    logic              last_d;
    logic              frame_q;
    logic              frame_d;
    logic              done_pending_q;
    logic              done_pending_d;
    logic              err_q;
    logic              err_d;

    logic              late_word_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    logic              clr_pending_s;

    assign fifo_full_s  = (count_q == FIFO_FULL_CNT);
    assign fifo_empty_s = (count_q == '0);
    assign fifo_rd_s    = fifo_mem_q[rd_ptr_q];

    // A word arriving after cw_done belongs to a message that must not start yet.
    assign late_word_s = done_pending_q & ~cw_done;
    assign push_s      = cw_rdy & ~fifo_full_s & ~late_word_s;
    assign drop_s      = cw_rdy & (fifo_full_s | late_word_s);

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Packing FSM: drain whole bytes first, then refill, then close the frame
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        bcnt_d        = bcnt_q;
        byte_d        = byte_q;
        valid_d       = valid_q;
        last_d        = last_q;
        frame_d       = 1'b0;
        clr_pending_s = 1'b0;
        pop_s         = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (bcnt_q >= BYTE_BITS) begin
                    byte_d  = acc_q[ACC_W-1 -: 8];
                    acc_d   = {acc_q[ACC_W-9:0], 8'h00};
                    bcnt_d  = bcnt_q - BYTE_BITS;
                    valid_d = 1'b1;
                    last_d  = done_pending_q & fifo_empty_s & (bcnt_q == BYTE_BITS);
                    state_d = ST_SEND;
                end else if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    acc_d   = acc_q | ({fifo_rd_s, 8'h00} >> bcnt_q);
                    bcnt_d  = bcnt_q + CW_BITS;
                    state_d = ST_FILL;
                end else if (done_pending_q && (bcnt_q != '0)) begin
                    // Residual bits are already left-aligned with zeros below them.
                    byte_d  = acc_q[ACC_W-1 -: 8];
                    acc_d   = '0;
                    bcnt_d  = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = ST_SEND;
                end else if (done_pending_q) begin
                    frame_d       = 1'b1;
                    clr_pending_s = 1'b1;
                    state_d       = ST_FILL;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_SEND: begin
                if (valid_q && byte_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d        = 1'b0;
                        frame_d       = 1'b1;
                        clr_pending_s = 1'b1;
                    end else begin
                        last_d = 1'b0;
                    end
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Message-end and error flags; a new cw_done wins over a same-cycle clear
    always_comb begin
        done_pending_d = done_pending_q;
        err_d          = err_q;
        if (cw_done) begin
            done_pending_d = 1'b1;
        end else if (clr_pending_s) begin
            done_pending_d = 1'b0;
        end else begin
            done_pending_d = done_pending_q;
        end
        if (drop_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // FIFO storage, written without reset since occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= cw_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packing datapath, output registers and flags
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= ST_FILL;
            acc_q          <= '0;
            bcnt_q         <= '0;
            byte_q         <= 8'h00;
            valid_q        <= 1'b0;
            last_q         <= 1'b0;
            frame_q        <= 1'b0;
            done_pending_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            bcnt_q         <= bcnt_d;
            byte_q         <= byte_d;
            valid_q        <= valid_d;
            last_q         <= last_d;
            frame_q        <= frame_d;
            done_pending_q <= done_pending_d;
            err_q          <= err_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign byte_last  = last_q;
    assign frame_done = frame_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cw_byte_packer.sv
// Self-checking bench for cw_byte_packer: directed vector table, backpressure and
// reset corner cases, and random-ready messages against a bit-stream reference model.
module tb_cw_byte_packer;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [17:0] cw_in = 18'h0;
    logic        cw_rdy = 1'b0;
    logic        cw_done = 1'b0;
    logic        byte_ready = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_last;
    logic        frame_done;
    logic        err;

    always #5 clk = ~clk;

    cw_byte_packer #(.CW_W(18), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_b(rst_b), .cw_in(cw_in), .cw_rdy(cw_rdy), .cw_done(cw_done),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .frame_done(frame_done), .err(err)
    );

    typedef struct {
        int         n;
        logic [17:0] word;
        int         gap;
        int         exp_bytes;
        logic [7:0] exp_last;
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    logic [17:0] msg_q[$];
    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    int          frame_cnt = 0;
    int          frame_cyc = 0;
    int          last_xfer_cyc = 0;
    int          first_valid_cyc = -1;
    int          rdy_cyc = 0;
    int          hold_err = 0;
    logic        prev_hold = 1'b0;
    logic [8:0]  prev_val = 9'h0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor, sampled mid-cycle: a transfer happens at the next rising edge
    initial forever begin
        @(negedge clk);
        if (rst_b) begin
            if (byte_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_hold && (!byte_valid || {byte_last, byte_out} != prev_val)) hold_err++;
            if (byte_valid && byte_ready) begin
                got_q.push_back({byte_last, byte_out});
                last_xfer_cyc = cyc;
            end
            if (frame_done) begin
                frame_cnt++;
                frame_cyc = cyc;
            end
            prev_hold = byte_valid && !byte_ready;
            prev_val  = {byte_last, byte_out};
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference packing: stream bit k is word k/18, bit 17-(k%18); zero past the end
    function automatic void build_expected(input int nwords);
        int total;
        int nb;
        total = nwords * 18;
        nb = (total + 7) / 8;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            logic [7:0] v;
            v = 8'h00;
            for (int j = 0; j < 8; j++) begin
                int k;
                k = b * 8 + j;
                if (k < total) v[7-j] = msg_q[k / 18][17 - (k % 18)];
            end
            exp_q.push_back({(b == nb - 1), v});
        end
    endfunction

    task automatic clear_mon();
        got_q.delete();
        frame_cnt = 0;
        first_valid_cyc = -1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        cw_rdy = 1'b0;
        cw_done = 1'b0;
        byte_ready = 1'b0;
        cw_in = 18'h0;
        step(2);
        clear_mon();
        rst_b = 1'b1;
        step(1);
    endtask

    task automatic compare_got(input string tag, input int n);
        for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // Drive msg_q with a fixed gap, cw_done alongside the final word, until frame_done
    task automatic run_msg(input int gap, input bit rnd, input int max_cyc);
        int sent;
        int cnt;
        int n;
        bit done_flag;
        sent = 0;
        cnt = 0;
        n = msg_q.size();
        done_flag = 1'b0;
        for (int c = 0; c < max_cyc && !done_flag; c++) begin
            cw_rdy = 1'b0;
            cw_done = 1'b0;
            if (rnd) byte_ready = 1'($urandom_range(0, 1));
            if (n == 0 && c == 0) begin
                cw_done = 1'b1;
            end else if (sent < n) begin
                if (cnt == 0) begin
                    cw_in = msg_q[sent];
                    cw_rdy = 1'b1;
                    if (sent == n - 1) cw_done = 1'b1;
                    if (sent == 0) rdy_cyc = cyc;
                    sent++;
                    cnt = gap - 1;
                end else begin
                    cnt--;
                end
            end
            step(1);
            if (sent == n && frame_cnt > 0) done_flag = 1'b1;
        end
        cw_rdy = 1'b0;
        cw_done = 1'b0;
        byte_ready = 1'b1;
        chk("frame_seen", 32'(done_flag), 32'd1);
        step(4);
    endtask

    initial begin
        vecs[0] = '{n: 10, word: 18'h3FFFF, gap: 20, exp_bytes: 23, exp_last: 8'hF0};
        vecs[1] = '{n: 1,  word: 18'h20001, gap: 5,  exp_bytes: 3,  exp_last: 8'h40};
        vecs[2] = '{n: 8,  word: 18'h15555, gap: 6,  exp_bytes: 18, exp_last: 8'h55};
        vecs[3] = '{n: 4,  word: 18'h00000, gap: 6,  exp_bytes: 9,  exp_last: 8'h00};
        vecs[4] = '{n: 0,  word: 18'h00000, gap: 1,  exp_bytes: 0,  exp_last: 8'h00};
        vecs[5] = '{n: 3,  word: 18'h2AAAA, gap: 6,  exp_bytes: 7,  exp_last: 8'hA8};

        rst_b = 1'b0;
        step(2);
        chk("reset_outputs", 32'({byte_valid, byte_last, frame_done, err, byte_out}), 32'd0);
        rst_b = 1'b1;

        for (int v = 0; v < 6; v++) begin
            int nlast;
            do_reset();
            byte_ready = 1'b1;
            msg_q.delete();
            for (int i = 0; i < vecs[v].n; i++) msg_q.push_back(vecs[v].word);
            run_msg(vecs[v].gap, 1'b0, 2000);
            build_expected(vecs[v].n);
            chk($sformatf("v%0d_count", v), 32'(got_q.size()), 32'(vecs[v].exp_bytes));
            compare_got($sformatf("v%0d", v), exp_q.size());
            nlast = 0;
            foreach (got_q[i]) if (got_q[i][8]) nlast++;
            chk($sformatf("v%0d_nlast", v), 32'(nlast), (vecs[v].exp_bytes > 0) ? 32'd1 : 32'd0);
            if (got_q.size() > 0) begin
                chk($sformatf("v%0d_lastbyte", v), 32'(got_q[got_q.size()-1]), 32'({1'b1, vecs[v].exp_last}));
                chk($sformatf("v%0d_latency", v), 32'(first_valid_cyc - rdy_cyc), 32'd3);
                chk($sformatf("v%0d_frame_delay", v), 32'(frame_cyc - last_xfer_cyc), 32'd1);
            end
            chk($sformatf("v%0d_frames", v), 32'(frame_cnt), 32'd1);
            chk($sformatf("v%0d_err", v), 32'(err), 32'd0);
        end

        // Backpressure: six back-to-back words with the sink stalled
        do_reset();
        byte_ready = 1'b0;
        msg_q.delete();
        for (int i = 0; i < 6; i++) msg_q.push_back(18'($urandom_range(0, 262143)));
        for (int i = 0; i < 6; i++) begin
            cw_in = msg_q[i];
            cw_rdy = 1'b1;
            step(1);
        end
        cw_rdy = 1'b0;
        step(4);
        chk("bp_valid", 32'(byte_valid), 32'd1);
        chk("bp_first_byte", 32'(byte_out), 32'(msg_q[0][17:10]));
        chk("bp_err", 32'(err), 32'd1);
        step(10);
        byte_ready = 1'b1;
        for (int c = 0; c < 200 && got_q.size() < 11; c++) step(1);
        step(20);
        build_expected(5);
        chk("bp_count", 32'(got_q.size()), 32'd11);
        compare_got("bp", 11);
        chk("bp_err_sticky", 32'(err), 32'd1);
        cw_done = 1'b1;
        step(1);
        cw_done = 1'b0;
        for (int c = 0; c < 100 && frame_cnt == 0; c++) step(1);
        chk("bp_final_count", 32'(got_q.size()), 32'd12);
        compare_got("bp_final", 12);
        chk("bp_frames", 32'(frame_cnt), 32'd1);

        // Reset in the middle of a message, with err still set from above
        clear_mon();
        msg_q.delete();
        msg_q.push_back(18'($urandom_range(0, 262143)));
        msg_q.push_back(18'($urandom_range(0, 262143)));
        cw_in = msg_q[0];
        cw_rdy = 1'b1;
        step(1);
        cw_rdy = 1'b0;
        step(5);
        cw_in = msg_q[1];
        cw_rdy = 1'b1;
        step(1);
        cw_rdy = 1'b0;
        for (int c = 0; c < 100 && got_q.size() < 3; c++) step(1);
        chk("mid_bytes_before_reset", 32'(got_q.size()), 32'd3);
        rst_b = 1'b0;
        #1;
        chk("mid_reset_outputs", 32'({byte_valid, byte_last, frame_done, err, byte_out}), 32'd0);
        step(2);
        clear_mon();
        rst_b = 1'b1;
        step(1);
        msg_q.delete();
        msg_q.push_back(18'($urandom_range(0, 262143)));
        run_msg(5, 1'b0, 500);
        build_expected(1);
        chk("post_reset_count", 32'(got_q.size()), 32'd3);
        compare_got("post_reset", 3);
        chk("post_reset_frames", 32'(frame_cnt), 32'd1);

        // Random sink readiness over 10-word random messages
        for (int r = 0; r < 2; r++) begin
            do_reset();
            msg_q.delete();
            for (int i = 0; i < 10; i++) msg_q.push_back(18'($urandom_range(0, 262143)));
            run_msg(14, 1'b1, 3000);
            build_expected(10);
            chk($sformatf("rnd%0d_count", r), 32'(got_q.size()), 32'd23);
            compare_got($sformatf("rnd%0d", r), exp_q.size());
            chk($sformatf("rnd%0d_frames", r), 32'(frame_cnt), 32'd1);
            chk($sformatf("rnd%0d_err", r), 32'(err), 32'd0);
        end

        chk("hold_stable", 32'(hold_err), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
